sar_search: RTL and testbench
=============================

# sar_search

- Successive-approximation search controller: the inverse of the magnitude comparator.
- The comparator maps an (A, B) pair to a relation (grt/sma/eq). This block drives a trial operand and reads the relation back, recovering an unknown target value MSB-first in at most WIDTH compare cycles.
- It sits on the A side of an external combinational comparator whose B side holds the target.

## Interface
- WIDTH, 4, operand width in bits (≥2)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request a new search; honoured only while idle
- guess  out  WIDTH  registered trial operand, drives comparator A input
- grt  in  1  comparator: guess > target
- sma  in  1  comparator: guess < target
- eq  in  1  comparator: guess == target
- busy  out  1  search in progress
- done  out  1  one-cycle completion pulse
- found  out  1  eq was observed during the last search (valid with done, held after)
- err  out  1  last search aborted on an illegal relation (valid with done, held after)
- result  out  WIDTH  recovered target, updated only at completion, held until the next completion

## Operation
- States: IDLE, TRY.
- IDLE:
  - On start=1: guess <= 1<<(WIDTH-1); bit index k <= WIDTH-1; busy <= 1; found <= 0; err <= 0; go to TRY.
  - start=0: no change.
- TRY samples grt/sma/eq for the current guess every cycle.
- Relation legality: exactly one of grt, sma, eq is high. Otherwise: err <= 1, result <= 0, done <= 1, busy <= 0, guess <= 0, go to IDLE.
- eq=1: result <= guess; found <= 1; done <= 1; busy <= 0; go to IDLE (early exit).
- grt=1: bit k of the trial is cleared.
- sma=1: bit k of the trial is kept.
- If k>0 after the grt/sma decision: set bit k-1 of guess; k <= k-1; stay in TRY.
- If k==0 after the grt/sma decision: result <= decided value (bit 0 applied); found <= 0; done <= 1; busy <= 0; go to IDLE.
  - The decided value equals the target for a consistent comparator, e.g. target 0 ends here with result 0.
- guess holds its last value in IDLE, except after err, when guess = 0.
- start while busy=1: ignored, no effect on the search.
- Arithmetic: pure bit set/clear on WIDTH-bit registers, no adders. k is a ceil(log2(WIDTH))-bit down-counter.

## Timing
- Reset (async assert, sync release): state IDLE, guess=0, busy=0, done=0, found=0, err=0, result=0, k=0.
- Reset during TRY aborts immediately. No done pulse is produced.
- start sampled at edge N: guess and busy valid after edge N; first relation sampled at edge N+1.
- Latency from the start edge to the done edge: 1 cycle best case (eq on first trial), WIDTH cycles worst case.
- done is high for exactly one cycle, the first IDLE cycle.
- start high in the done cycle is accepted: back-to-back searches with no dead cycle.
- busy and done are never high together.
- The comparator is combinational. grt/sma/eq must settle within the same cycle guess changes.

## Test plan
- WIDTH=4, target 5:
  - Trials: 8 (grt), 4 (sma), 6 (grt), 5 (eq).
  - Required: done on the 4th TRY cycle, result=5, found=1, err=0.
- target 0:
  - Trials: 8, 4, 2, 1, all grt.
  - Required: done after 4 cycles, result=0, found=0, err=0.
- target 8:
  - Required: eq on the first trial, done 1 cycle after start, result=8, found=1.
- Sweep targets 0..15 back-to-back, start asserted in each done cycle:
  - Required: every result equals its target, no idle gap between searches.
  - Required: start pulses during busy change nothing.
- Fault injection: force grt=sma=1 on the 2nd trial.
  - Required: done with err=1, result=0, guess=0.
  - Required: the next clean search (target 3) clears err and returns result=3.
- Assert rst_n low mid-search (target 11, after 2 trials).
  - Required: all outputs 0 immediately, no done.
  - Required: a search after release returns result=11.

Source files
------------

// File: rtl/sar_search.sv
// Successive-approximation search controller: drives a trial operand into an
// external comparator and recovers the comparator's B-side target MSB-first.
module sar_search #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] guess,
  input  logic             grt,
  input  logic             sma,
  input  logic             eq,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  localparam int KW = $clog2(WIDTH);

  typedef enum logic {IDLE, TRY} state_t;

  state_t           state;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] bit_k;
  logic [WIDTH-1:0] decided;
  logic [WIDTH-1:0] next_trial;
  logic             legal;

  // decided applies the grt/sma verdict to bit k; next_trial also seeds bit k-1
  always_comb begin
    bit_k      = {{(WIDTH-1){1'b0}}, 1'b1} << k;
    decided    = sma ? guess : (guess & ~bit_k);
    next_trial = decided | (bit_k >> 1);
    legal      = ({grt, sma, eq} == 3'b100) ||
                 ({grt, sma, eq} == 3'b010) ||
                 ({grt, sma, eq} == 3'b001);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      guess  <= '0;
      k      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      found  <= 1'b0;
      err    <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            guess <= {1'b1, {(WIDTH-1){1'b0}}};
            k     <= KW'(WIDTH - 1);
            busy  <= 1'b1;
            found <= 1'b0;
            err   <= 1'b0;
            state <= TRY;
          end
        end
        TRY: begin
          if (!legal) begin
            err    <= 1'b1;
            result <= '0;
            guess  <= '0;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end else if (eq) begin
            result <= guess;
            found  <= 1'b1;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end else if (k != '0) begin
            guess <= next_trial;
            k     <= k - KW'(1);
          end else begin
            result <= decided;
            found  <= 1'b0;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search: a comparator model drives the relation inputs and a
// cycle-level model of the search outcome is compared against the DUT every cycle.
module tb_sar_search;

  localparam int W   = 4;
  localparam int LIM = 20;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] guess;
  logic         grt, sma, eq;
  logic         busy, done, found, err;
  logic [W-1:0] result;

  logic [W-1:0] target;
  logic         fault_arm;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  logic         m_busy, m_done, m_found, m_err, m_fault;
  logic [W-1:0] m_result, m_tgt;
  int           m_cnt;

  sar_search #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .guess  (guess),
    .grt    (grt),
    .sma    (sma),
    .eq     (eq),
    .busy   (busy),
    .done   (done),
    .found  (found),
    .err    (err),
    .result (result)
  );

  always #5 clk = ~clk;

  // Environment: combinational comparator, with an injected illegal relation
  always_comb begin
    grt = (guess > target);
    sma = (guess < target);
    eq  = (guess == target);
    if (m_busy && m_fault && m_cnt == 2) begin
      grt = 1'b1;
      sma = 1'b1;
      eq  = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Binary search ends at the trial whose bit equals the target's lowest set bit
  function automatic int latency(input int t);
    int n = 0;
    if (t == 0) return W;
    while (t % 2 == 0) begin
      t = t / 2;
      n++;
    end
    return W - n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_done <= 0; m_found <= 0; m_err <= 0;
      m_result <= 0; m_cnt <= 0; m_fault <= 0; m_tgt <= 0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (start) begin
          m_busy  <= 1'b1;
          m_cnt   <= 1;
          m_tgt   <= target;
          m_fault <= fault_arm;
          m_found <= 1'b0;
          m_err   <= 1'b0;
        end
      end else if (m_fault && m_cnt == 2) begin
        m_err <= 1'b1; m_result <= '0; m_done <= 1'b1; m_busy <= 1'b0;
      end else if (m_cnt == latency(int'(m_tgt))) begin
        m_result <= m_tgt; m_found <= (m_tgt != 0); m_done <= 1'b1; m_busy <= 1'b0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("found", found, m_found);
      check("err", err, m_err);
      check("result", result, m_result);
      check("busy_done_excl", busy & done, 0);
    end
  end

  task automatic search(input int t, input logic flt, output int cyc);
    target    = W'(t);
    fault_arm = flt;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc   = 0;
    while (!done && cyc < LIM) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("timeout", cyc < LIM, 1);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; start = 1'b0; target = '0; fault_arm = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_guess", guess, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    search(5, 0, cyc);
    check("t5_cycles", cyc, 4);
    check("t5_result", result, 5);
    check("t5_found", found, 1);
    check("t5_err", err, 0);

    search(0, 0, cyc);
    check("t0_cycles", cyc, 4);
    check("t0_result", result, 0);
    check("t0_found", found, 0);

    search(8, 0, cyc);
    check("t8_cycles", cyc, 1);
    check("t8_result", result, 8);
    check("t8_found", found, 1);
    @(posedge clk); #1;
    check("t8_guess_held", guess, 8);

    // Back-to-back sweep; odd targets also see start pulses while busy
    target = '0; start = 1'b1;
    @(posedge clk); #1;
    for (int t = 0; t < 16; t++) begin
      cyc = 0;
      while (!done && cyc < LIM) begin
        check("sweep_no_gap", busy, 1);
        start = (t % 2 == 1);
        @(posedge clk); #1;
        cyc++;
      end
      check("sweep_timeout", cyc < LIM, 1);
      check("sweep_result", result, t);
      start = (t < 15);
      if (t < 15) target = W'(t + 1);
      @(posedge clk); #1;
    end
    start = 1'b0;
    @(posedge clk); #1;

    search(9, 1, cyc);
    check("flt_cycles", cyc, 2);
    check("flt_err", err, 1);
    check("flt_result", result, 0);
    check("flt_guess", guess, 0);

    search(3, 0, cyc);
    check("post_flt_err", err, 0);
    check("post_flt_result", result, 3);

    // Reset partway through the third trial
    target = 4'd11; fault_arm = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_guess", guess, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_found", found, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_result", result, 0);
    @(posedge clk); #1;
    check("rst_held_done", done, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_done", done, 0);

    search(11, 0, cyc);
    check("t11_cycles", cyc, 4);
    check("t11_result", result, 11);
    check("t11_found", found, 1);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
